// File: rtl/iq_packer.sv
// Packs pairs of 2-bit I/Q GPS samples (or a self-test counter) into bytes and
// queues them in a first-word-fall-through FIFO with overflow accounting.
module iq_packer #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic       MCU_CLK_25_000,
  input  logic       RESET_P,
  input  logic       DATAREADY,
  input  logic       GPS_I0,
  input  logic       GPS_I1,
  input  logic       GPS_Q0,
  input  logic       GPS_Q1,
  input  logic       SELF_TEST,
  input  logic       BYTE_READY,
  output logic       BYTE_VALID,
  output logic [7:0] BYTE_DATA,
  output logic       OVERFLOW,
  output logic [7:0] DROP_COUNT
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;
  localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};

  logic            phase_q, phase_d;
  logic [3:0]      hold_q, hold_d;
  logic [3:0]      tcnt_q, tcnt_d;
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic            ovf_q, ovf_d;
  logic [7:0]      drop_q, drop_d;
  logic [7:0]      mem_q [DEPTH];

  logic [3:0]      nibble_s;
  logic [7:0]      byte_s;
  logic            empty_s, full_s, wr_s, pop_s, push_s, drop_s;

  // Sample selection, FIFO status and the write/pop/drop decision for this edge.
  always_comb begin
    nibble_s = SELF_TEST ? tcnt_q : {GPS_I1, GPS_I0, GPS_Q1, GPS_Q0};
    byte_s   = {hold_q, nibble_s};
    empty_s  = (wptr_q == rptr_q);
    full_s   = (wptr_q[DEPTH_LOG2] != rptr_q[DEPTH_LOG2]) &&
               (wptr_q[DEPTH_LOG2-1:0] == rptr_q[DEPTH_LOG2-1:0]);
    wr_s     = DATAREADY & phase_q;
    pop_s    = ~empty_s & BYTE_READY;
    // A full FIFO still accepts the byte when the head leaves at the same edge.
    push_s   = wr_s & (~full_s | pop_s);
    drop_s   = wr_s & full_s & ~pop_s;
  end

  // Next-state values for the packer, pointers and overflow accounting.
  always_comb begin
    phase_d = phase_q;
    hold_d  = hold_q;
    tcnt_d  = tcnt_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    ovf_d   = ovf_q;
    drop_d  = drop_q;
    if (DATAREADY) begin
      phase_d = ~phase_q;
      if (!phase_q) begin
        hold_d = nibble_s;
      end else begin
        hold_d = hold_q;
      end
      if (SELF_TEST) begin
        tcnt_d = tcnt_q + 4'd1;
      end else begin
        tcnt_d = tcnt_q;
      end
    end else begin
      phase_d = phase_q;
    end
    if (push_s) begin
      wptr_d = wptr_q + PTR_ONE;
    end else begin
      wptr_d = wptr_q;
    end
    if (pop_s) begin
      rptr_d = rptr_q + PTR_ONE;
    end else begin
      rptr_d = rptr_q;
    end
    if (drop_s) begin
      ovf_d = 1'b1;
      if (drop_q != 8'hFF) begin
        drop_d = drop_q + 8'd1;
      end else begin
        drop_d = drop_q;
      end
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge MCU_CLK_25_000 or posedge RESET_P) begin
    if (RESET_P) begin
      phase_q <= 1'b0;
      hold_q  <= 4'h0;
      tcnt_q  <= 4'h0;
      wptr_q  <= {PW{1'b0}};
      rptr_q  <= {PW{1'b0}};
      ovf_q   <= 1'b0;
      drop_q  <= 8'h00;
    end else begin
      phase_q <= phase_d;
      hold_q  <= hold_d;
      tcnt_q  <= tcnt_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
    end
  end

  // Byte storage; contents are meaningless once the pointers are reset.
  always_ff @(posedge MCU_CLK_25_000) begin
    if (push_s) begin
      mem_q[wptr_q[DEPTH_LOG2-1:0]] <= byte_s;
    end
  end

  assign BYTE_VALID = ~empty_s;
  assign BYTE_DATA  = empty_s ? 8'h00 : mem_q[rptr_q[DEPTH_LOG2-1:0]];
  assign OVERFLOW   = ovf_q;
  assign DROP_COUNT = drop_q;

endmodule

// File: tb/tb_iq_packer.sv
// Self-checking bench for iq_packer: directed vector table, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_iq_packer;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       DATAREADY, GPS_I0, GPS_I1, GPS_Q0, GPS_Q1, SELF_TEST, BYTE_READY;
  logic       BYTE_VALID, OVERFLOW;
  logic [7:0] BYTE_DATA, DROP_COUNT;

  int tests = 0;
  int fails = 0;

  // reference model state
  logic [7:0] mq[$];
  logic       m_phase;
  logic [3:0] m_hold;
  int         m_tcnt;
  int         m_drops;
  logic       m_ovf;

  logic [7:0] got[$];

  typedef struct {
    logic       dr;
    logic [3:0] bits;
    logic       st;
    logic       rdy;
    logic       exp_valid;
    logic [7:0] exp_data;
  } vec_t;
  vec_t vecs[10];

  iq_packer #(.DEPTH_LOG2(3)) dut (
    .MCU_CLK_25_000(clk),
    .RESET_P(rst),
    .DATAREADY(DATAREADY),
    .GPS_I0(GPS_I0),
    .GPS_I1(GPS_I1),
    .GPS_Q0(GPS_Q0),
    .GPS_Q1(GPS_Q1),
    .SELF_TEST(SELF_TEST),
    .BYTE_READY(BYTE_READY),
    .BYTE_VALID(BYTE_VALID),
    .BYTE_DATA(BYTE_DATA),
    .OVERFLOW(OVERFLOW),
    .DROP_COUNT(DROP_COUNT)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_phase = 1'b0;
    m_hold  = 4'h0;
    m_tcnt  = 0;
    m_drops = 0;
    m_ovf   = 1'b0;
  endtask

  // One clock edge of the behaviour described in the requirements.
  task automatic model_step(input logic dr, input logic [3:0] bits, input logic st, input logic rdy);
    logic [3:0] nib;
    logic       popped;
    popped = (mq.size() > 0) && rdy;
    if (popped) void'(mq.pop_front());
    if (dr) begin
      nib = st ? 4'(m_tcnt) : bits;
      if (st) m_tcnt = (m_tcnt + 1) % 16;
      if (!m_phase) begin
        m_hold = nib;
      end else if (mq.size() < DEPTH) begin
        mq.push_back({m_hold, nib});
      end else begin
        m_drops++;
        m_ovf = 1'b1;
      end
      m_phase = ~m_phase;
    end
  endtask

  task automatic check_model();
    chk("model_valid", int'(BYTE_VALID), int'(mq.size() > 0));
    if (mq.size() > 0) chk("model_data", int'(BYTE_DATA), int'(mq[0]));
    chk("model_overflow", int'(OVERFLOW), int'(m_ovf));
    chk("model_drops", int'(DROP_COUNT), (m_drops > 255) ? 255 : m_drops);
  endtask

  task automatic cycle(input logic dr, input logic [3:0] bits, input logic st, input logic rdy);
    DATAREADY  = dr;
    {GPS_I1, GPS_I0, GPS_Q1, GPS_Q0} = bits;
    SELF_TEST  = st;
    BYTE_READY = rdy;
    model_step(dr, bits, st, rdy);
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    DATAREADY = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (BYTE_VALID) got.push_back(BYTE_DATA);
      cycle(1'b0, 4'h0, 1'b0, 1'b1);
    end
  endtask

  initial begin
    rst = 1'b1;
    DATAREADY = 1'b0; GPS_I0 = 1'b0; GPS_I1 = 1'b0; GPS_Q0 = 1'b0; GPS_Q1 = 1'b0;
    SELF_TEST = 1'b0; BYTE_READY = 1'b0;
    model_reset();

    // reset state before any clock edge
    #3;
    chk("reset_valid", int'(BYTE_VALID), 0);
    chk("reset_data", int'(BYTE_DATA), 8'h00);
    chk("reset_overflow", int'(OVERFLOW), 0);
    chk("reset_drops", int'(DROP_COUNT), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // directed table: the B4 example, then two mixed-source bytes
    vecs[0] = '{1'b1, 4'b1011, 1'b0, 1'b1, 1'b0, 8'h00};
    vecs[1] = '{1'b1, 4'b0100, 1'b0, 1'b1, 1'b1, 8'hB4};
    vecs[2] = '{1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 8'h00};
    vecs[3] = '{1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 8'h00};
    vecs[4] = '{1'b1, 4'b0000, 1'b1, 1'b1, 1'b0, 8'h00};
    vecs[5] = '{1'b1, 4'b1111, 1'b0, 1'b1, 1'b1, 8'h0F};
    vecs[6] = '{1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 8'h00};
    vecs[7] = '{1'b1, 4'b0001, 1'b0, 1'b1, 1'b0, 8'h00};
    vecs[8] = '{1'b1, 4'b1010, 1'b1, 1'b1, 1'b1, 8'h11};
    vecs[9] = '{1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 8'h00};
    for (int v = 0; v < 10; v++) begin
      cycle(vecs[v].dr, vecs[v].bits, vecs[v].st, vecs[v].rdy);
      chk($sformatf("vec%0d_valid", v), int'(BYTE_VALID), int'(vecs[v].exp_valid));
      if (vecs[v].exp_valid) chk($sformatf("vec%0d_data", v), int'(BYTE_DATA), int'(vecs[v].exp_data));
    end

    // self-test pattern over 32 strobes, wrapping the counter once
    do_reset();
    got.delete();
    for (int i = 0; i < 32; i++) begin
      if (BYTE_VALID) got.push_back(BYTE_DATA);
      cycle(1'b1, 4'h0, 1'b1, 1'b1);
    end
    drain(3);
    chk("selftest_count", got.size(), 16);
    for (int i = 0; i < 16 && i < got.size(); i++)
      chk($sformatf("selftest_byte%0d", i), int'(got[i]), ((((2 * i) % 16) << 4) | ((2 * i + 1) % 16)));

    // overflow by three bytes, then drain exactly the first eight
    do_reset();
    for (int i = 0; i < 2 * (DEPTH + 3); i++) cycle(1'b1, 4'h0, 1'b1, 1'b0);
    chk("ovf3_valid", int'(BYTE_VALID), 1);
    chk("ovf3_head", int'(BYTE_DATA), 8'h01);
    chk("ovf3_overflow", int'(OVERFLOW), 1);
    chk("ovf3_drops", int'(DROP_COUNT), 3);
    got.delete();
    drain(20);
    chk("ovf3_drain_count", got.size(), 8);
    for (int i = 0; i < 8 && i < got.size(); i++)
      chk($sformatf("ovf3_drain%0d", i), int'(got[i]), (((2 * i) << 4) | (2 * i + 1)));
    chk("ovf3_sticky", int'(OVERFLOW), 1);

    // full FIFO, phase-1 write coincides with a transfer: no drop
    do_reset();
    for (int i = 0; i < 2 * DEPTH; i++) cycle(1'b1, 4'h0, 1'b1, 1'b0);
    cycle(1'b1, 4'h0, 1'b1, 1'b0);
    cycle(1'b1, 4'h0, 1'b1, 1'b1);
    chk("fullxfer_drops", int'(DROP_COUNT), 0);
    chk("fullxfer_overflow", int'(OVERFLOW), 0);
    got.delete();
    drain(20);
    chk("fullxfer_count", got.size(), 8);
    for (int i = 0; i < 8 && i < got.size(); i++)
      chk($sformatf("fullxfer_drain%0d", i), int'(got[i]), (i == 7) ? 8'h01 : (((2 * i + 2) << 4) | (2 * i + 3)));

    // drop counter saturation
    do_reset();
    for (int i = 0; i < 2 * (DEPTH + 254); i++) cycle(1'b1, 4'($urandom), 1'b0, 1'b0);
    chk("sat_254", int'(DROP_COUNT), 254);
    cycle(1'b1, 4'h3, 1'b0, 1'b0);
    cycle(1'b1, 4'h9, 1'b0, 1'b0);
    chk("sat_255", int'(DROP_COUNT), 255);
    for (int i = 0; i < 2 * 45; i++) cycle(1'b1, 4'($urandom), 1'b0, 1'b0);
    chk("sat_300", int'(DROP_COUNT), 255);
    chk("sat_overflow", int'(OVERFLOW), 1);

    // asynchronous reset mid-byte with three bytes queued
    do_reset();
    for (int i = 0; i < 7; i++) cycle(1'b1, 4'h0, 1'b1, 1'b0);
    chk("midrst_pre_valid", int'(BYTE_VALID), 1);
    DATAREADY = 1'b0;
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("midrst_valid", int'(BYTE_VALID), 0);
    chk("midrst_data", int'(BYTE_DATA), 8'h00);
    chk("midrst_overflow", int'(OVERFLOW), 0);
    chk("midrst_drops", int'(DROP_COUNT), 0);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    cycle(1'b1, 4'b1010, 1'b0, 1'b0);
    chk("midrst_first_valid", int'(BYTE_VALID), 0);
    cycle(1'b1, 4'b0101, 1'b0, 1'b0);
    chk("midrst_fresh_valid", int'(BYTE_VALID), 1);
    chk("midrst_fresh_data", int'(BYTE_DATA), 8'hA5);

    // randomized traffic with varying downstream backpressure
    do_reset();
    for (int seg = 0; seg < 3; seg++) begin
      int p;
      p = (seg == 0) ? 80 : (seg == 1) ? 25 : 60;
      for (int i = 0; i < 300; i++)
        cycle(1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 99) < p));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/iq_packer.md
IQ_PACKER -- requirements
Module: iq_packer

Interface
REQ-001 Parameter DEPTH_LOG2, default 3: FIFO depth is 2**DEPTH_LOG2 bytes; legal range 1-5.
REQ-002 MCU_CLK_25_000  in  1  sole clock; all logic on its rising edge.
REQ-003 RESET_P  in  1  reset, asynchronous, active-high.
REQ-004 DATAREADY  in  1  one-cycle strobe, one per GPS sample, already synchronous to MCU_CLK_25_000.
REQ-005 GPS_I0, GPS_I1, GPS_Q0, GPS_Q1  in  1 each  synchronized sample bits, valid in the DATAREADY cycle.
REQ-006 SELF_TEST  in  1  selects the test-pattern source instead of the GPS bits.
REQ-007 BYTE_READY  in  1  downstream SPI stage can accept a byte.
REQ-008 BYTE_VALID  out  1  BYTE_DATA holds a valid byte.
REQ-009 BYTE_DATA  out  8  packed byte, first-in first-out.
REQ-010 OVERFLOW  out  1  sticky flag: at least one byte dropped since reset.
REQ-011 DROP_COUNT  out  8  count of dropped bytes, saturating.

Function
REQ-012 Sample nibble = {GPS_I1, GPS_I0, GPS_Q1, GPS_Q0}, bit 3 to bit 0.
REQ-013 SELF_TEST is sampled on every DATAREADY cycle; when 1, that nibble is replaced by a 4-bit test counter value.
REQ-014 The test counter increments by 1 on every DATAREADY cycle with SELF_TEST=1, wraps 15->0, and holds its value otherwise.
REQ-015 A phase bit toggles on every DATAREADY; phase 0 stores the nibble in a hold register; phase 1 forms byte {hold, current nibble}.
REQ-016 Sample order: first sample goes to bits 7:4, second sample to bits 3:0.
REQ-017 Switching SELF_TEST mid-byte does not reset phase; the byte mixes sources.
REQ-018 The byte is written into the FIFO at the same edge that samples the phase-1 DATAREADY; write latency is 1 cycle.
REQ-019 FIFO is first-word-fall-through; BYTE_VALID = FIFO not empty; BYTE_DATA = head entry.
REQ-020 A transfer occurs on an edge where BYTE_VALID=1 and BYTE_READY=1; the head advances at that edge.
REQ-021 BYTE_DATA and BYTE_VALID are stable while BYTE_VALID=1 and BYTE_READY=0.
REQ-022 Read and write pointers are DEPTH_LOG2+1 bits and wrap modulo 2**(DEPTH_LOG2+1); full/empty come from MSB comparison.
REQ-023 Write when full and no transfer in the same cycle: byte discarded, FIFO unchanged, OVERFLOW set to 1, DROP_COUNT incremented.
REQ-024 Write when full with a transfer in the same cycle: write accepted, no drop, occupancy unchanged.
REQ-025 Write and transfer in the same cycle when the FIFO holds one entry: head pops, new byte becomes head, BYTE_VALID stays 1.
REQ-026 DROP_COUNT saturates at 255; OVERFLOW stays 1 until reset.
REQ-027 BYTE_READY with BYTE_VALID=0 has no effect.

Reset
REQ-028 RESET_P=1 immediately sets, with no clock required: BYTE_VALID=0, BYTE_DATA=8'h00, OVERFLOW=0, DROP_COUNT=0, phase=0, hold=0, test counter=0, both pointers=0.
REQ-029 Reset mid-byte or mid-transfer discards the partial nibble and all FIFO contents.
REQ-030 After RESET_P deasserts, the first DATAREADY is phase 0.

Verification
REQ-031 Sequence:
- SELF_TEST=0, BYTE_READY=1.
- Sample 1: I1,I0,Q1,Q0 = 1,0,1,1.
- Sample 2: I1,I0,Q1,Q0 = 0,1,0,0.
- Required: BYTE_DATA=8'hB4, BYTE_VALID high for exactly 1 cycle, starting the cycle after the second strobe.
REQ-032 SELF_TEST=1, 32 strobes, BYTE_READY=1 -> bytes 8'h01, 8'h23, ..., 8'hEF, 8'h01, ..., 8'hEF.
REQ-033 BYTE_READY=0, 2*(2**DEPTH_LOG2+3) strobes -> 8 bytes held, OVERFLOW=1, DROP_COUNT=3; then BYTE_READY=1 -> exactly the first 8 bytes drain, in order.
REQ-034 Sequence:
- FIFO full.
- A phase-1 strobe in the same cycle as a transfer.
- Required: no drop, DROP_COUNT unchanged, FIFO still full.
REQ-035 Overflow with 300 drops -> DROP_COUNT=255.
REQ-036 RESET_P pulse mid-clock after one phase-0 strobe with 3 bytes queued -> outputs clear with no clock edge; the next two strobes form a fresh byte.
